// File: rtl/mips_multicycle_core_if.sv
// Unified instruction/data memory port with a req/ready handshake.
// The core drives the request side (master); memory answers (slave).
interface mips_multicycle_core_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS subset core: one shared ALU, one unified memory port with
// wait states, and a sticky HALT on illegal or misaligned operations.
module mips_multicycle_core #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter bit          REG_INIT_ZERO = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    mips_multicycle_core_if.master mem,
    output logic                   halted,
    output logic [31:0]            pc_out
);
    localparam int DATA_W = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_LWWB, S_MEMWR, S_EXEC_R,
        S_RWB, S_EXEC_I, S_IWB, S_BRANCH, S_JUMP, S_HALT
    } state_t;

    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_fn_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   ir_q, ir_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [DATA_W-1:0]   alu_out_q, alu_out_d;
    logic [DATA_W-1:0]   mdr_q, mdr_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [DATA_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                halted_q, halted_d;

    logic [DATA_W-1:0]   rf_q [32];
    logic                rf_we;
    logic [4:0]          rf_waddr;
    logic [DATA_W-1:0]   rf_wdata;

    logic [5:0]          opcode, funct;
    logic [4:0]          rs, rt, rd;
    logic signed [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0]   rs_val, rt_val;

    alu_fn_t             alu_fn, r_fn;
    logic                r_fn_ok;
    logic signed [DATA_W-1:0] alu_a, alu_b;
    logic [DATA_W-1:0]   alu_y;
    logic                accept;

    function automatic logic signed [DATA_W-1:0] sext16(input logic [15:0] v);
        return {{(DATA_W-16){v[15]}}, v};
    endfunction

    function automatic logic [DATA_W-1:0] alu_f(input alu_fn_t fn,
                                                input logic signed [DATA_W-1:0] x,
                                                input logic signed [DATA_W-1:0] y);
        case (fn)
            ALU_SUB: return x - y;
            ALU_AND: return x & y;
            ALU_OR:  return x | y;
            ALU_SLT: return {{(DATA_W-1){1'b0}}, (x < y)};
            default: return x + y;
        endcase
    endfunction

    assign opcode   = ir_q[31:26];
    assign rs       = ir_q[25:21];
    assign rt       = ir_q[20:16];
    assign rd       = ir_q[15:11];
    assign funct    = ir_q[5:0];
    assign imm_sext = sext16(ir_q[15:0]);
    assign rs_val   = (rs == 5'd0) ? '0 : rf_q[rs];
    assign rt_val   = (rt == 5'd0) ? '0 : rf_q[rt];

    // mem_req is registered, so ready only counts once the request is visible
    assign accept   = mem_req_q & mem.mem_ready;

    always_comb begin
        r_fn_ok = 1'b1;
        r_fn    = ALU_ADD;
        case (funct)
            FN_ADD:  r_fn = ALU_ADD;
            FN_SUB:  r_fn = ALU_SUB;
            FN_AND:  r_fn = ALU_AND;
            FN_OR:   r_fn = ALU_OR;
            FN_SLT:  r_fn = ALU_SLT;
            default: r_fn_ok = 1'b0;
        endcase
    end

    // Shared ALU: operands chosen by the current state
    always_comb begin
        alu_a  = a_q;
        alu_b  = imm_sext;
        alu_fn = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                alu_a = pc_q;
                alu_b = 32'sd4;
            end
            S_DECODE: begin
                alu_a = pc_q;
                alu_b = imm_sext <<< 2;
            end
            S_EXEC_R: begin
                alu_b  = b_q;
                alu_fn = r_fn;
            end
            default: ;
        endcase
        alu_y = alu_f(alu_fn, alu_a, alu_b);
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        alu_out_d = alu_out_q;
        mdr_d     = mdr_q;
        rf_we     = 1'b0;
        rf_waddr  = rt;
        rf_wdata  = alu_out_q;
        case (state_q)
            S_FETCH: if (accept) begin
                ir_d    = mem.mem_rdata;
                pc_d    = alu_y;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                a_d       = rs_val;
                b_d       = rt_val;
                alu_out_d = alu_y;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC_R;
                    OP_ADDI:      state_d = S_EXEC_I;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_HALT;
                endcase
            end
            S_MEMADR: begin
                alu_out_d = alu_y;
                if (alu_y[1:0] != 2'b00)  state_d = S_HALT;
                else if (opcode == OP_LW) state_d = S_MEMRD;
                else                      state_d = S_MEMWR;
            end
            S_MEMRD: if (accept) begin
                mdr_d   = mem.mem_rdata;
                state_d = S_LWWB;
            end
            S_LWWB: begin
                rf_we    = 1'b1;
                rf_wdata = mdr_q;
                state_d  = S_FETCH;
            end
            S_MEMWR: if (accept) state_d = S_FETCH;
            S_EXEC_R: begin
                if (r_fn_ok) begin
                    alu_out_d = alu_y;
                    state_d   = S_RWB;
                end else begin
                    state_d = S_HALT;
                end
            end
            S_RWB: begin
                rf_we    = 1'b1;
                rf_waddr = rd;
                state_d  = S_FETCH;
            end
            S_EXEC_I: begin
                alu_out_d = alu_y;
                state_d   = S_IWB;
            end
            S_IWB: begin
                rf_we   = 1'b1;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                if (a_q == b_q) pc_d = alu_out_q;
                state_d = S_FETCH;
            end
            S_JUMP: begin
                pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
                state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_HALT;
        endcase

        // Bus outputs are registered from the next state so they hold steady while waiting
        mem_req_d   = (state_d == S_FETCH) || (state_d == S_MEMRD) || (state_d == S_MEMWR);
        mem_we_d    = (state_d == S_MEMWR);
        mem_addr_d  = (state_d == S_FETCH) ? pc_d : alu_out_d;
        mem_wdata_d = b_d;
        halted_d    = (state_d == S_HALT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            ir_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            alu_out_q   <= '0;
            mdr_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= RESET_PC;
            mem_wdata_q <= '0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            a_q         <= a_d;
            b_q         <= b_d;
            alu_out_q   <= alu_out_d;
            mdr_q       <= mdr_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            halted_q    <= halted_d;
        end
    end

    generate
        if (REG_INIT_ZERO) begin : g_rf_clr
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int i = 0; i < 32; i++) rf_q[i] <= '0;
                end else if (rf_we && rf_waddr != 5'd0) begin
                    rf_q[rf_waddr] <= rf_wdata;
                end
            end
        end else begin : g_rf_keep
            always_ff @(posedge clk) begin
                if (rf_we && rf_waddr != 5'd0) rf_q[rf_waddr] <= rf_wdata;
            end
        end
    endgenerate

    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign halted        = halted_q;
    assign pc_out        = pc_q;
endmodule

// File: tb/tb_mips_multicycle_core.sv
// Bench for mips_multicycle_core: memory responder with programmable waits and an
// instruction-level reference model that predicts bus traffic, latency and PC flow.
module tb_mips_multicycle_core;
    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam int K_NONE = 0, K_RD = 1, K_WR = 2, K_HALT = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        halted;
    logic [31:0] pc_out;

    mips_multicycle_core_if bus ();

    mips_multicycle_core #(.RESET_PC(RESET_PC), .REG_INIT_ZERO(1'b1)) dut (
        .clk    (clk),
        .reset  (reset),
        .mem    (bus),
        .halted (halted),
        .pc_out (pc_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] mem  [1024];
    logic [31:0] m_rf [32];
    logic [31:0] m_pc;
    logic [31:0] last_wdata;
    logic [31:0] last_next;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [25:0] tgt);
        return {6'h02, tgt};
    endfunction

    task automatic put(input logic [31:0] addr, input logic [31:0] w);
        mem[addr[11:2]] = w;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    endtask

    task automatic do_reset();
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk1("rst_req", bus.mem_req, 1'b0);
        chk1("rst_we", bus.mem_we, 1'b0);
        chk1("rst_halted", halted, 1'b0);
        chk("rst_pc", pc_out, RESET_PC);
        reset = 1'b1;
        m_pc = RESET_PC;
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
    endtask

    task automatic wait_req(output logic ok);
        int n = 0;
        while (bus.mem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = (bus.mem_req === 1'b1);
    endtask

    // Called at a negedge with mem_req high; completes the access after 'waits' stall cycles.
    task automatic service(input int waits);
        logic [31:0] a0, d0;
        logic        w0, stable;
        a0 = bus.mem_addr;
        d0 = bus.mem_wdata;
        w0 = bus.mem_we;
        stable = 1'b1;
        bus.mem_ready = 1'b0;
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            if (bus.mem_req !== 1'b1 || bus.mem_addr !== a0 || bus.mem_we !== w0 ||
                (w0 && bus.mem_wdata !== d0))
                stable = 1'b0;
        end
        if (waits > 0) chk1("bus_stable", stable, 1'b1);
        bus.mem_rdata = mem[a0[11:2]];
        bus.mem_ready = 1'b1;
        @(negedge clk);
        if (w0) mem[a0[11:2]] = d0;
        bus.mem_ready = 1'b0;
    endtask

    // ISA-level reference: one instruction, architectural effect plus expected bus access.
    task automatic model_step(input logic [31:0] ins, output int kind, output logic [31:0] ea,
                              output logic [31:0] wd, output int nom);
        logic [5:0]  op, fn;
        int          rs, rt, rd;
        logic [31:0] a, b, simm, pc4, res;
        op   = ins[31:26];
        fn   = ins[5:0];
        rs   = int'(ins[25:21]);
        rt   = int'(ins[20:16]);
        rd   = int'(ins[15:11]);
        a    = m_rf[rs];
        b    = m_rf[rt];
        simm = {{16{ins[15]}}, ins[15:0]};
        pc4  = m_pc + 32'd4;
        kind = K_NONE;
        ea   = '0;
        wd   = '0;
        nom  = 4;
        res  = '0;
        m_pc = pc4;
        case (op)
            6'h00: begin
                case (fn)
                    6'h20:   res = a + b;
                    6'h22:   res = a - b;
                    6'h24:   res = a & b;
                    6'h25:   res = a | b;
                    6'h2A:   res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    default: kind = K_HALT;
                endcase
                if (kind != K_HALT && rd != 0) m_rf[rd] = res;
            end
            6'h08: if (rt != 0) m_rf[rt] = a + simm;
            6'h23, 6'h2B: begin
                ea = a + simm;
                if (ea[1:0] != 2'b00) kind = K_HALT;
                else if (op == 6'h23) begin
                    kind = K_RD;
                    nom  = 5;
                    if (rt != 0) m_rf[rt] = mem[ea[11:2]];
                end else begin
                    kind = K_WR;
                    wd   = b;
                end
            end
            6'h04: begin
                nom = 3;
                if (a == b) m_pc = pc4 + (simm << 2);
            end
            6'h02: begin
                nom  = 3;
                m_pc = {pc4[31:28], ins[25:0], 2'b00};
            end
            default: kind = K_HALT;
        endcase
    endtask

    task automatic exec_one(input int fw, input int dw);
        logic        ok, req_seen;
        int          t0, kind, nom, dwx, n;
        logic [31:0] ins, ea, wd;
        wait_req(ok);
        chk1("fetch_req", ok, 1'b1);
        if (!ok) return;
        t0 = cyc;
        chk("fetch_addr", bus.mem_addr, m_pc);
        chk1("fetch_we", bus.mem_we, 1'b0);
        chk("pc_out", pc_out, m_pc);
        ins = mem[m_pc[11:2]];
        service(fw);
        model_step(ins, kind, ea, wd, nom);
        if (kind == K_HALT) begin
            n = 0;
            req_seen = 1'b0;
            while (halted !== 1'b1 && n < 2) begin
                if (bus.mem_req !== 1'b0) req_seen = 1'b1;
                @(negedge clk);
                n++;
            end
            chk1("halt", halted, 1'b1);
            repeat (4) begin
                if (bus.mem_req !== 1'b0) req_seen = 1'b1;
                @(negedge clk);
            end
            chk1("halt_noreq", req_seen, 1'b0);
            chk1("halt_sticky", halted, 1'b1);
            return;
        end
        dwx = 0;
        if (kind == K_RD || kind == K_WR) begin
            wait_req(ok);
            chk1("data_req", ok, 1'b1);
            if (ok) begin
                chk("data_addr", bus.mem_addr, ea);
                chk1("data_we", bus.mem_we, kind == K_WR);
                if (kind == K_WR) begin
                    chk("data_wdata", bus.mem_wdata, wd);
                    last_wdata = bus.mem_wdata;
                end
                dwx = dw;
                service(dw);
            end
        end
        wait_req(ok);
        chk1("next_fetch_req", ok, 1'b1);
        chk("latency", 32'(cyc - t0), 32'(nom + fw + dwx));
        chk("next_pc", bus.mem_addr, m_pc);
        last_next = bus.mem_addr;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        ok, flag;
        logic [5:0]  fns [5];
        reset = 1'b0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h24; fns[3] = 6'h25; fns[4] = 6'h2A;

        // Arithmetic with fetch waits, then load/store
        clear_mem();
        put(32'h100, enc_i(6'h08, 0, 1, 16'd5));
        put(32'h104, enc_i(6'h08, 0, 2, 16'hFFFD));
        put(32'h108, enc_r(1, 2, 3, 6'h20));
        put(32'h10C, enc_r(2, 1, 4, 6'h2A));
        put(32'h110, enc_r(2, 1, 5, 6'h22));
        put(32'h114, enc_i(6'h2B, 0, 3, 16'h0300));
        put(32'h118, enc_i(6'h2B, 0, 4, 16'h0304));
        put(32'h11C, enc_i(6'h2B, 0, 5, 16'h0308));
        put(32'h120, enc_i(6'h23, 0, 1, 16'h0400));
        put(32'h124, enc_i(6'h2B, 0, 1, 16'h0008));
        put(32'h128, enc_i(6'h23, 0, 6, 16'h0008));
        put(32'h12C, enc_i(6'h2B, 0, 6, 16'h030C));
        put(32'h130, enc_i(6'h23, 0, 0, 16'h0400));
        put(32'h134, enc_i(6'h2B, 0, 0, 16'h0310));
        put(32'h400, 32'hDEAD_BEEF);
        do_reset();
        repeat (5) exec_one(2, 0);
        exec_one(0, 0); chk("sum_r3", last_wdata, 32'd2);
        exec_one(0, 1); chk("slt_r4", last_wdata, 32'd1);
        exec_one(1, 2); chk("sub_r5", last_wdata, 32'hFFFF_FFF8);
        exec_one(0, 0);
        exec_one(0, 0); chk("sw_deadbeef", last_wdata, 32'hDEAD_BEEF);
        exec_one(0, 0);
        exec_one(0, 0); chk("lw_r6", last_wdata, 32'hDEAD_BEEF);
        exec_one(0, 0);
        exec_one(0, 0); chk("lw_r0_discard", last_wdata, 32'd0);

        // Branches and jumps
        clear_mem();
        put(32'h100, enc_j(26'h4));
        put(32'h010, enc_i(6'h04, 7, 0, 16'd2));
        put(32'h01C, enc_i(6'h08, 0, 7, 16'd1));
        put(32'h020, enc_j(26'h40));
        put(32'h014, enc_i(6'h04, 0, 0, 16'hFFFF));
        do_reset();
        exec_one(0, 0); chk("j_to_10", last_next, 32'h10);
        exec_one(1, 0); chk("beq_taken", last_next, 32'h1C);
        exec_one(0, 0);
        exec_one(0, 0); chk("j_0x40", last_next, 32'h100);
        exec_one(0, 0);
        exec_one(0, 0); chk("beq_not_taken", last_next, 32'h14);
        exec_one(0, 0); chk("beq_self_loop", last_next, 32'h14);
        exec_one(2, 0); chk("beq_self_loop2", last_next, 32'h14);

        // Traps
        clear_mem(); put(RESET_PC, {6'h3F, 26'd0});               do_reset(); exec_one(0, 0);
        clear_mem(); put(RESET_PC, enc_r(1, 2, 3, 6'h3F));        do_reset(); exec_one(1, 0);
        clear_mem(); put(RESET_PC, enc_i(6'h23, 0, 1, 16'h0006)); do_reset(); exec_one(0, 0);

        // Randomized arithmetic, results dumped with stores
        clear_mem();
        for (int i = 0; i < 3; i++)
            put(RESET_PC + 32'(4 * i), enc_i(6'h08, 0, i + 1, 16'($urandom)));
        for (int i = 3; i < 23; i++) begin
            if ($urandom_range(0, 4) == 0)
                put(RESET_PC + 32'(4 * i), enc_i(6'h08, $urandom_range(0, 7), $urandom_range(0, 7), 16'($urandom)));
            else
                put(RESET_PC + 32'(4 * i), enc_r($urandom_range(0, 7), $urandom_range(0, 7),
                                                 $urandom_range(0, 7), fns[$urandom_range(0, 4)]));
        end
        for (int i = 0; i < 7; i++)
            put(RESET_PC + 32'(4 * (23 + i)), enc_i(6'h2B, 0, i + 1, 16'(32'h300 + 4 * i)));
        do_reset();
        for (int i = 0; i < 30; i++) exec_one($urandom_range(0, 2), $urandom_range(0, 2));

        // Reset in the middle of a stalled store
        clear_mem();
        put(32'h100, enc_i(6'h08, 0, 1, 16'h0055));
        put(32'h104, enc_i(6'h2B, 0, 1, 16'h0500));
        do_reset();
        exec_one(0, 0);
        wait_req(ok);
        chk1("mw_fetch_req", ok, 1'b1);
        service(0);
        wait_req(ok);
        chk1("mw_req", ok, 1'b1);
        chk1("mw_we", bus.mem_we, 1'b1);
        bus.mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1 chk1("mw_req_drop", bus.mem_req, 1'b0);
        bus.mem_ready = 1'b1;
        flag = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.mem_req !== 1'b0) flag = 1'b1;
        end
        reset = 1'b1;
        @(negedge clk);
        if (bus.mem_req === 1'b1 && bus.mem_we === 1'b1) flag = 1'b1;
        bus.mem_ready = 1'b0;
        chk1("mw_no_write", flag, 1'b0);
        wait_req(ok);
        chk1("mw_refetch_req", ok, 1'b1);
        chk("mw_refetch_addr", bus.mem_addr, RESET_PC);
        chk1("mw_refetch_we", bus.mem_we, 1'b0);
        chk("mw_pc_out", pc_out, RESET_PC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/mips_multicycle_core.md
Name: mips_multicycle_core

Overview:
Multi-cycle successor to the single-cycle MIPS top. It runs the same MIPS subset through a control FSM, with one shared ALU and one unified memory port that uses a ready handshake, so memory may insert wait states. It also adds a correctly word-scaled branch offset, an addi opcode, and a trap/halt state on illegal or misaligned operations. It sits between a unified instruction/data memory and the board-level top.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.
REG_INIT_ZERO, 1, 1 = all 32 registers cleared on reset; 0 = only the pipeline regs and PC are cleared.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
mem_req  output  1  memory access request, held until accepted.
mem_we  output  1  1 = write, 0 = read; valid while mem_req=1.
mem_addr  output  32  byte address; always word aligned when mem_req=1.
mem_wdata  output  32  store data.
mem_rdata  input  32  read data; valid in the cycle mem_ready=1.
mem_ready  input  1  access completes in the cycle where mem_req & mem_ready.
halted  output  1  core is in HALT.
pc_out  output  32  current architectural PC.

Behaviour:
- Reset (reset=0, async): PC=RESET_PC; IR, A, B, ALUOut, MDR=0; FSM=FETCH; mem_req=0, mem_we=0, halted=0. Registers are cleared if REG_INIT_ZERO=1. A reset mid-access abandons the access; the next access starts with FETCH.
- Supported instructions:
  - R-type (op 0x00) with funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A (signed).
  - lw 0x23, sw 0x2B, beq 0x04, j 0x02, addi 0x08.
  - Anything else goes to HALT.
- Register file: 32x32, two combinational reads, one write on the clock edge. Writes to $0 are ignored and $0 always reads 0.
- Arithmetic: 32-bit wrap-around; overflow is ignored, with no trap.
- FSM states and transitions:
  - FETCH: mem_req=1, mem_we=0, mem_addr=PC. Stays here while mem_ready=0. On ready: IR<=mem_rdata, PC<=PC+4, go to DECODE.
  - DECODE: A<=rs, B<=rt, ALUOut<=PC+(sext(imm)<<2) (branch target). The opcode selects the next state: MEMADR, EXEC_R, EXEC_I, BRANCH or JUMP. An illegal opcode goes to HALT.
  - MEMADR: ALUOut<=A+sext(imm). If the result has bits[1:0]≠0, go to HALT. Otherwise lw goes to MEMRD and sw goes to MEMWR.
  - MEMRD: read request at ALUOut, waits for ready. On ready: MDR<=mem_rdata, go to LWWB.
  - LWWB: rt<=MDR, go to FETCH.
  - MEMWR: mem_we=1, mem_wdata=B, waits for ready, then go to FETCH.
  - EXEC_R: ALUOut<=A op B. An illegal funct goes to HALT; otherwise go to RWB.
  - RWB: rd<=ALUOut, go to FETCH.
  - EXEC_I: ALUOut<=A+sext(imm), go to IWB.
  - IWB: rt<=ALUOut, go to FETCH.
  - BRANCH: if A==B, PC<=ALUOut. Go to FETCH.
  - JUMP: PC<={PC[31:28],IR[25:0],2'b00}, using the already-incremented PC. Go to FETCH.
  - HALT: absorbing state; halted=1, mem_req=0. Only reset leaves it.
- Latency with zero wait states:
  - beq and j: 3 cycles.
  - R-type, addi and sw: 4 cycles.
  - lw: 5 cycles.
  - Each cycle with mem_ready=0 during a request adds exactly 1 cycle.
- Handshake:
  - mem_addr, mem_we and mem_wdata stay stable while mem_req=1 and mem_ready=0.
  - mem_ready while mem_req=0 is ignored.
- Boundary cases:
  - PC increments wrap at 2^32.
  - A beq with rs==rt and offset -1 (0xFFFF) loops on itself.
  - lw into $0 performs the read but discards the data.
- pc_out = PC register, so it shows the fetch address during FETCH.

Test Plan:
- Reset: hold reset=0 with RESET_PC=0x100, then release. First request has mem_addr=0x100, mem_we=0, mem_req=1; halted=0.
- Arithmetic with waits: program `addi $1,$0,5`; `addi $2,$0,-3`; `add $3,$1,$2`; `slt $4,$2,$1`; `sub $5,$2,$1`, with mem_ready delayed 2 cycles on every fetch. Required: $3=2, $4=1, $5=0xFFFFFFF8; each instruction takes exactly 2 cycles longer than nominal.
- Load/store: `sw $1,8($0)` with $1=0xDEADBEEF, then `lw $6,8($0)`. Required: write request at address 8 with mem_wdata=0xDEADBEEF; $6=0xDEADBEEF; lw takes 5 cycles with zero wait.
- Branch and jump: beq at 0x10 with offset 2 and equal operands gives next fetch 0x1C; with unequal operands it gives 0x14. `j 0x40` at 0x20 gives next fetch 0x100.
- Traps: opcode 0x3F or funct 0x3F gives halted=1 within 2 cycles and mem_req stays 0. lw with an effective address of 0x6 halts without issuing a memory request.
- Async reset mid-MEMWR while mem_ready=0: mem_req drops immediately; after release, fetch restarts at RESET_PC and no write is ever accepted.
